// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Module   : core_pkg
// Brief    : Constants and types shared across the RV32 core pipeline.
// Revision : 1.0
// ============================================================================
package core_pkg;

  localparam logic [31:0] c_reset_pc   = 32'h0000_0000;
  localparam logic [31:0] c_ilen_bytes = 32'd4;
  localparam logic [31:0] c_nop        = 32'h0000_0013;

  // Fate of an instruction-memory response in the cycle it returns.
  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_PUSH = 2'd1,
    RESP_DROP = 2'd2
  } resp_kind_e;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_fifo
// Brief    : Shift-register instruction buffer; the head is a flop, no fall-through.
// Revision : 1.0
// ============================================================================
module fetch_fifo #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic [WIDTH-1:0] o_head,
  output logic [CW-1:0]    o_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [CW-1:0]    r_count;
  logic             w_pop;
  logic             w_push;
  logic [CW-1:0]    w_wr_slot;
  logic [AW-1:0]    w_wr_idx;

  assign w_pop     = i_pop & (r_count != '0);
  // Write lands behind the surviving entries, so a full buffer accepts push+pop.
  assign w_wr_slot = r_count - CW'(w_pop);
  assign w_wr_idx  = AW'(w_wr_slot);
  assign w_push    = i_push & (w_wr_slot < CW'(DEPTH));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_flush) begin
      r_count <= '0;
    end else begin
      if (w_pop) begin
        for (int i = 0; i < DEPTH - 1; i++) begin
          r_mem[i] <= r_mem[i+1];
        end
      end
      if (w_push) begin
        r_mem[w_wr_idx] <= i_data;
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  assign o_head  = r_mem[0];
  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/core_if_stage.sv
`default_nettype none
// ============================================================================
// Module   : core_if_stage
// Brief    : RV32 instruction fetch: credit-limited imem requests, buffered
//            responses and redirect flush with in-flight response dropping.
// Revision : 1.0
// ============================================================================
module core_if_stage
  import core_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(c_reset_pc),
  parameter int              DEPTH    = 2
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  output logic            o_imem_req,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_gnt,
  input  logic            i_imem_rvalid,
  input  logic [XLEN-1:0] i_imem_rdata,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_instr,
  output logic [XLEN-1:0] o_pc
);

  localparam int              CW           = $clog2(DEPTH + 1);
  localparam int              SW           = CW + 1;
  localparam logic [XLEN-1:0] c_step       = XLEN'(c_ilen_bytes);
  localparam logic [XLEN-1:0] c_align_mask = ~XLEN'(3);

  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_head_pc;
  logic [CW-1:0]   r_outstanding;
  logic [CW-1:0]   r_drop;

  logic [CW-1:0]   w_count;
  logic [XLEN-1:0] w_head;
  logic            w_pop;
  logic            w_grant;
  logic            w_credit;
  logic [SW-1:0]   w_credit_sum;
  logic [CW-1:0]   w_outstanding_ret;
  logic [XLEN-1:0] w_redirect_pc;
  resp_kind_e      w_resp_kind;

  assign w_pop = o_valid & i_ready;

  // Everything in flight or buffered holds a slot; a pop frees one this cycle.
  assign w_credit_sum = {1'b0, r_outstanding} + {1'b0, w_count} - SW'(w_pop);
  assign w_credit     = (w_credit_sum < SW'(DEPTH));
  assign o_imem_req   = i_rst_n & ~i_redirect & w_credit;
  assign o_imem_addr  = r_fetch_pc;
  assign w_grant      = o_imem_req & i_imem_gnt;

  assign w_redirect_pc     = i_redirect_pc & c_align_mask;
  assign w_outstanding_ret = r_outstanding - CW'(i_imem_rvalid);

  always_comb begin
    w_resp_kind = RESP_NONE;
    if (i_imem_rvalid) begin
      w_resp_kind = (i_redirect || (r_drop != '0)) ? RESP_DROP : RESP_PUSH;
    end
  end

  fetch_fifo #(
    .WIDTH (XLEN),
    .DEPTH (DEPTH)
  ) u_fetch_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_resp_kind == RESP_PUSH),
    .i_data  (i_imem_rdata),
    .i_pop   (w_pop),
    .i_flush (i_redirect),
    .o_head  (w_head),
    .o_count (w_count)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fetch_pc    <= RESET_PC;
      r_head_pc     <= RESET_PC;
      r_outstanding <= '0;
      r_drop        <= '0;
    end else if (i_redirect) begin
      // Every request still in flight after this cycle belongs to the old path.
      r_fetch_pc    <= w_redirect_pc;
      r_head_pc     <= w_redirect_pc;
      r_outstanding <= w_outstanding_ret;
      r_drop        <= w_outstanding_ret;
    end else begin
      if (w_grant) begin
        r_fetch_pc <= r_fetch_pc + c_step;
      end
      if (w_pop) begin
        r_head_pc <= r_head_pc + c_step;
      end
      r_outstanding <= w_outstanding_ret + CW'(w_grant);
      if (w_resp_kind == RESP_DROP) begin
        r_drop <= r_drop - CW'(1);
      end
    end
  end

  assign o_valid = (w_count != '0);
  assign o_instr = w_head;
  assign o_pc    = r_head_pc;

  a_rvalid_needs_request : assert property (
    @(posedge i_clk) disable iff (!i_rst_n) i_imem_rvalid |-> (r_outstanding != '0));

  a_credit_bound : assert property (
    @(posedge i_clk) disable iff (!i_rst_n)
      (({1'b0, r_outstanding} + {1'b0, w_count}) <= SW'(DEPTH)));

  a_drop_bound : assert property (
    @(posedge i_clk) disable iff (!i_rst_n) (r_drop <= r_outstanding));

endmodule
`default_nettype wire

// File: tb/tb_core_if_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_core_if_stage
// Brief    : Self-checking bench: imem model with random stalls/latency and an
//            in-order PC-stream reference for the decode side.
// Revision : 1.0
// ============================================================================
module tb_core_if_stage;

  localparam int          XLEN     = 32;
  localparam int          DEPTH    = 3;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic            i_clk = 1'b0;
  logic            i_rst_n = 1'b0;
  logic            o_imem_req;
  logic [XLEN-1:0] o_imem_addr;
  logic            i_imem_gnt = 1'b0;
  logic            i_imem_rvalid = 1'b0;
  logic [XLEN-1:0] i_imem_rdata = '0;
  logic            i_redirect = 1'b0;
  logic [XLEN-1:0] i_redirect_pc = '0;
  logic            o_valid;
  logic            i_ready = 1'b1;
  logic [XLEN-1:0] o_instr;
  logic [XLEN-1:0] o_pc;

  core_if_stage #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC),
    .DEPTH    (DEPTH)
  ) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .o_imem_req    (o_imem_req),
    .o_imem_addr   (o_imem_addr),
    .i_imem_gnt    (i_imem_gnt),
    .i_imem_rvalid (i_imem_rvalid),
    .i_imem_rdata  (i_imem_rdata),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .o_valid       (o_valid),
    .i_ready       (i_ready),
    .o_instr       (o_instr),
    .o_pc          (o_pc)
  );

  always #5 i_clk = ~i_clk;

  int checks   = 0;
  int failures = 0;
  int n_grants = 0;
  logic rand_mode = 1'b0;
  logic mem_hold  = 1'b0;

  typedef struct {
    logic [31:0] addr;
    int          rdy;
  } ent_t;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_0F1E;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Memory model and decode-stream reference: stimulus at negedge+1, observe at negedge+4.
  initial begin : env
    int          cyc;
    int          stall;
    int          last_rdy;
    int          lat;
    int          rdy;
    logic [31:0] exp_pc;
    logic [31:0] exp_fetch;
    ent_t        q[$];
    cyc = 0; stall = 0; last_rdy = 0;
    exp_pc = RESET_PC; exp_fetch = RESET_PC;
    forever begin
      @(negedge i_clk);
      #1;
      cyc++;
      if (!i_rst_n) begin
        q.delete();
        stall = 0;
        last_rdy = 0;
      end
      i_imem_gnt = (stall == 0);
      if (i_rst_n && !mem_hold && q.size() > 0 && q[0].rdy <= cyc) begin
        i_imem_rvalid = 1'b1;
        i_imem_rdata  = mem_word(q[0].addr);
      end else begin
        i_imem_rvalid = 1'b0;
        i_imem_rdata  = $urandom;
      end
      #3;
      if (!i_rst_n) begin
        exp_pc = RESET_PC;
        exp_fetch = RESET_PC;
      end else begin
        if (i_imem_rvalid) void'(q.pop_front());
        if (i_redirect) chk("req_during_redirect", 32'(o_imem_req), 32'd0);
        if (o_imem_req && i_imem_gnt) begin
          chk("fetch_addr", o_imem_addr, exp_fetch);
          exp_fetch += 32'd4;
          n_grants++;
          lat = rand_mode ? int'($urandom_range(1, 4)) : 1;
          rdy = cyc + lat;
          if (rdy < last_rdy) rdy = last_rdy;
          last_rdy = rdy;
          q.push_back('{addr: o_imem_addr, rdy: rdy});
          stall = rand_mode ? int'($urandom_range(0, 3)) : 0;
        end else if (stall > 0) begin
          stall--;
        end
        if (o_valid && i_ready) begin
          chk("stream_pc", o_pc, exp_pc);
          chk("stream_instr", o_instr, mem_word(exp_pc));
          exp_pc += 32'd4;
        end
        if (i_redirect) begin
          exp_pc    = {i_redirect_pc[31:2], 2'b00};
          exp_fetch = exp_pc;
        end
        chk("inflight_le_depth", 32'(q.size() <= DEPTH), 32'd1);
      end
    end
  end

  initial begin : main
    int          g0;
    logic [31:0] hold_pc;
    logic [31:0] hold_instr;

    // Reset values
    repeat (3) @(negedge i_clk);
    #1;
    chk("rst_req", 32'(o_imem_req), 32'd0);
    chk("rst_addr", o_imem_addr, RESET_PC);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_instr", o_instr, 32'd0);
    chk("rst_pc", o_pc, RESET_PC);

    // Release: first instruction valid two cycles later
    @(negedge i_clk);
    i_rst_n = 1'b1;
    #1;
    chk("release_req", 32'(o_imem_req), 32'd1);
    chk("release_addr", o_imem_addr, RESET_PC);
    @(negedge i_clk);
    chk("first_valid_c1", 32'(o_valid), 32'd0);
    @(negedge i_clk);
    chk("first_valid_c2", 32'(o_valid), 32'd1);
    chk("first_pc", o_pc, RESET_PC);
    chk("first_instr", o_instr, mem_word(RESET_PC));
    repeat (8) begin
      @(negedge i_clk);
      chk("sustained_valid", 32'(o_valid), 32'd1);
    end

    // Decode back-pressure for five cycles
    @(negedge i_clk);
    i_ready    = 1'b0;
    g0         = n_grants;
    hold_pc    = o_pc;
    hold_instr = o_instr;
    repeat (5) begin
      @(negedge i_clk);
      chk("stall_valid", 32'(o_valid), 32'd1);
      chk("stall_pc", o_pc, hold_pc);
      chk("stall_instr", o_instr, hold_instr);
    end
    chk("stall_grants_le_depth", 32'((n_grants - g0) <= DEPTH), 32'd1);
    chk("req_when_full", 32'(o_imem_req), 32'd0);

    // One pop plus a request whose response is held: 1 in flight, 2 buffered
    i_ready  = 1'b1;
    mem_hold = 1'b1;
    @(negedge i_clk);
    i_ready       = 1'b0;
    i_redirect    = 1'b1;
    i_redirect_pc = 32'h0000_0100;
    #1;
    chk("redirect_req_low", 32'(o_imem_req), 32'd0);
    @(negedge i_clk);
    i_redirect = 1'b0;
    mem_hold   = 1'b0;
    i_ready    = 1'b1;
    chk("flush_valid_n1", 32'(o_valid), 32'd0);
    chk("redirect_addr", o_imem_addr, 32'h0000_0100);
    @(negedge i_clk);
    chk("flush_valid_n2", 32'(o_valid), 32'd0);
    @(negedge i_clk);
    chk("redirect_valid_n3", 32'(o_valid), 32'd1);
    chk("redirect_pc", o_pc, 32'h0000_0100);
    chk("redirect_instr", o_instr, mem_word(32'h0000_0100));

    // Misaligned redirect target
    repeat (4) @(negedge i_clk);
    i_redirect    = 1'b1;
    i_redirect_pc = 32'h0000_0203;
    @(negedge i_clk);
    i_redirect = 1'b0;
    chk("align_addr", o_imem_addr, 32'h0000_0200);
    @(negedge i_clk);
    @(negedge i_clk);
    chk("align_valid", 32'(o_valid), 32'd1);
    chk("align_pc", o_pc, 32'h0000_0200);

    // Fetch address wraps at the top of the address space
    i_redirect    = 1'b1;
    i_redirect_pc = 32'hFFFF_FFFC;
    @(negedge i_clk);
    i_redirect = 1'b0;
    chk("wrap_addr_top", o_imem_addr, 32'hFFFF_FFFC);
    @(negedge i_clk);
    chk("wrap_addr_zero", o_imem_addr, 32'h0000_0000);
    @(negedge i_clk);
    chk("wrap_pc_top", o_pc, 32'hFFFF_FFFC);
    @(negedge i_clk);
    chk("wrap_valid", 32'(o_valid), 32'd1);
    chk("wrap_pc_zero", o_pc, 32'h0000_0000);

    // Random grant stalls, response latency, back-pressure and redirects
    rand_mode = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge i_clk);
      i_ready       = ($urandom_range(0, 3) != 0);
      i_redirect    = ($urandom_range(0, 49) == 0);
      i_redirect_pc = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 4095)) : $urandom;
    end
    @(negedge i_clk);
    i_redirect = 1'b0;
    i_ready    = 1'b1;
    rand_mode  = 1'b0;
    repeat (20) @(negedge i_clk);

    // Reset asserted mid-stream
    i_rst_n = 1'b0;
    #1;
    chk("midrst_req", 32'(o_imem_req), 32'd0);
    chk("midrst_addr", o_imem_addr, RESET_PC);
    chk("midrst_valid", 32'(o_valid), 32'd0);
    chk("midrst_instr", o_instr, 32'd0);
    chk("midrst_pc", o_pc, RESET_PC);
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    chk("rerelease_valid_c1", 32'(o_valid), 32'd0);
    @(negedge i_clk);
    chk("rerelease_valid_c2", 32'(o_valid), 32'd1);
    chk("rerelease_pc", o_pc, RESET_PC);
    repeat (5) @(negedge i_clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/core_if_stage.md
# core_if_stage

Instruction-fetch stage of the in-order RV32 pipeline. Holds the fetch PC, issues word requests to instruction memory over a req/gnt/rvalid handshake, buffers returned instructions in a small FIFO, and presents them with their PC to the decode stage under a valid/ready handshake. Branch/jump redirects from later stages flush buffered and in-flight instructions and restart fetch at the new PC.

## Interface
- XLEN, 32, data/address width
- RESET_PC, 32'h0000_0000, first fetch address after reset
- DEPTH, 2, fetch-buffer entries and maximum outstanding-plus-buffered instructions (>= 1)

- i_clk  input  1  clock, all state updates on rising edge
- i_rst_n  input  1  asynchronous active-low reset
- o_imem_req  output  1  fetch request
- o_imem_addr  output  XLEN  word-aligned fetch address
- i_imem_gnt  input  1  request accepted this cycle
- i_imem_rvalid  input  1  response valid (in order, >= 1 cycle after its grant)
- i_imem_rdata  input  XLEN  instruction word
- i_redirect  input  1  redirect fetch (taken branch/jump)
- i_redirect_pc  input  XLEN  redirect target
- o_valid  output  1  o_instr/o_pc hold an instruction for decode
- i_ready  input  1  decode accepts this cycle
- o_instr  output  XLEN  instruction word to decode
- o_pc  output  XLEN  address of o_instr

## Operation
- State: fetch_pc, head_pc, outstanding counter, drop counter, FIFO (count 0..DEPTH); counters $clog2(DEPTH+1) bits.
- Reset values: fetch_pc = head_pc = RESET_PC; counters 0; FIFO empty; o_imem_req 0, o_imem_addr RESET_PC, o_valid 0, o_instr 0, o_pc RESET_PC.
- pop = o_valid & i_ready. Credit rule: o_imem_req = ~i_redirect & (outstanding + count - pop < DEPTH). o_imem_addr = fetch_pc.
- Grant (req & gnt): fetch_pc += 4 (mod 2^XLEN, wraps silently), outstanding += 1.
- Response (rvalid): outstanding -= 1; if drop > 0, drop -= 1 and data discarded; else data pushed to FIFO. Grant and response in same cycle: outstanding unchanged.
- o_valid = FIFO non-empty; o_instr = FIFO head; o_pc = head_pc. On pop, head_pc += 4. Push and pop in same cycle legal, including when full.
- Redirect (highest priority): fetch_pc = head_pc = {i_redirect_pc[XLEN-1:2], 2'b00}; FIFO flushed; no request issued; drop = outstanding after this cycle's response is retired (response arriving this cycle is discarded). o_valid low next cycle. A pop in the redirect cycle still completes for decode but does not affect head_pc.
- Redirect while drop > 0: drop = current in-flight count (replaces, never adds beyond outstanding).
- Memory side must tolerate req withdrawal on redirect; address not held across redirect.
- rvalid with outstanding == 0 is a protocol error (assertion; no state change required).

## Timing
- Zero-wait memory (gnt combinational, rvalid next cycle): first instruction o_valid 2 cycles after reset release; sustained 1 instr/cycle with i_ready high and DEPTH >= 2.
- Redirect cycle N: new address on o_imem_addr in N+1; its instruction valid at N+3 with zero-wait memory.
- i_ready low: FIFO fills; req drops once outstanding + count reaches DEPTH; no data loss.
- Reset asserted mid-operation: all state returns to reset values immediately; in-flight responses after release are not expected (memory reset together).

## Structure
- Shared core_pkg: RESET_PC default, ILEN/word-increment constant 4, NOP encoding 32'h0000_0013.
- One sub-module: fetch_fifo (synchronous FIFO, DEPTH entries, push/pop/flush, count, registered head output, no fall-through).

## Test plan
- Reset release, zero-wait memory, i_ready=1 -> addresses 0x0,0x4,0x8...; first o_valid at cycle 2 with o_pc=0x0; then one instruction per cycle.
- i_ready=0 for 5 cycles -> at most DEPTH requests granted, o_instr/o_pc stable, correct order resumes on i_ready=1.
- Redirect to 0x100 with 1 in-flight and 2 buffered -> FIFO flushed, in-flight response dropped, next o_valid o_pc=0x100.
- i_redirect_pc=0x203 -> fetch address 0x200, o_pc 0x200.
- Random gnt stall (0-3 cycles) and rvalid latency (1-4 cycles) vs. reference model -> instruction/PC stream matches, outstanding never exceeds DEPTH.
- fetch_pc=0xFFFF_FFFC -> next request address 0x0000_0000; reset asserted mid-stream -> outputs at reset values same cycle.
